gray_conv_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one Gray-to-binary converter between several requesters. Each requester presents a W-bit Gray-coded word, such as a rotary-encoder or CDC pointer value. The block grants one requester at a time, captures its word and converts it through a single registered prefix-XOR stage. It returns the binary result with the requester ID over a valid/ready output handshake.

---
 rtl/gray_conv_arbiter.sv | 110 +++++++++++
 tb/tb_gray_conv_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter sharing one registered Gray-to-binary converter between
// N_REQ requesters; results leave over a valid/ready handshake with the winner's ID.
module gray_conv_arbiter #(
  parameter  int unsigned N_REQ = 4,
  parameter  int unsigned W     = 4,
  localparam int unsigned IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] gray_in,
  output logic [N_REQ-1:0]   gnt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W-1:0]       bin_out,
  output logic [IDW-1:0]     out_id,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, CONV, HOLD} state_t;

  state_t           state_q;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   id_q, win_id_d;
  logic [IDW-1:0]   out_id_q;
  logic [W-1:0]     gray_q, gray_d;
  logic [W-1:0]     bin_q;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             valid_q, busy_q, win_found;

  function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
    logic [W-1:0] b;
    b      = '0;
    b[W-1] = g[W-1];
    for (int unsigned i = 1; i < W; i++) begin
      b[W-1-i] = b[W-i] ^ g[W-1-i];
    end
    return b;
  endfunction

  // Search starts at ptr_q and wraps at N_REQ, which need not be a power of two.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    win_found = 1'b0;
    win_id_d  = '0;
    gnt_d     = '0;
    gray_d    = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!win_found && req[idx]) begin
        win_found  = 1'b1;
        win_id_d   = IDW'(idx);
        gnt_d[idx] = 1'b1;
        gray_d     = gray_in[idx*W +: W];
      end
    end
    ptr_d = (win_id_d == IDW'(N_REQ - 1)) ? '0 : win_id_d + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      id_q     <= '0;
      gray_q   <= '0;
      gnt_q    <= '0;
      valid_q  <= 1'b0;
      bin_q    <= '0;
      out_id_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_found) begin
            gray_q  <= gray_d;
            id_q    <= win_id_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            busy_q  <= 1'b1;
            state_q <= CONV;
          end
        end
        CONV: begin
          gnt_q    <= '0;
          bin_q    <= gray2bin(gray_q);
          out_id_q <= id_q;
          valid_q  <= 1'b1;
          state_q  <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign out_valid = valid_q;
  assign bin_out   = bin_q;
  assign out_id    = out_id_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Self-checking bench for gray_conv_arbiter: directed scenarios plus randomized
// transactions against a transaction-level round-robin / Gray-decode model.
module tb_gray_conv_arbiter;
  localparam int unsigned N   = 4;
  localparam int unsigned W   = 4;
  localparam int unsigned IDW = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req;
  logic [N*W-1:0]   gray_in;
  logic [N-1:0]     gnt;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     bin_out;
  logic [IDW-1:0]   out_id;
  logic             busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_gnt = 0;
  int mptr     = 0;

  gray_conv_arbiter #(.N_REQ(N), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .gray_in(gray_in), .gnt(gnt),
    .out_valid(out_valid), .out_ready(out_ready), .bin_out(bin_out),
    .out_id(out_id), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // binary = XOR of all right-shifts of the Gray word
  function automatic logic [W-1:0] ref_bin(input logic [W-1:0] g);
    logic [W-1:0] b;
    b = g;
    for (int s = 1; s < W; s++) b = b ^ (g >> s);
    return b;
  endfunction

  function automatic int model_pick(input logic [N-1:0] r);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (mptr + k) % N;
      if (r[i]) begin
        mptr = (i + 1) % N;
        return i;
      end
    end
    return -1;
  endfunction

  function automatic logic [N*W-1:0] rnd_gray();
    logic [N*W-1:0] v;
    for (int i = 0; i < N; i++) v[i*W +: W] = W'($urandom);
    return v;
  endfunction

  task automatic txn(input logic [N-1:0] r, input logic [N*W-1:0] g, input int hold,
                     input bit keep, input int exp_gap, output int oid, output logic [W-1:0] obin);
    int win;
    logic [W-1:0] eb;
    oid  = -1;
    obin = '0;
    req = r; gray_in = g; out_ready = (hold == 0);
    win = model_pick(r);
    @(posedge clk); @(negedge clk);
    if (win < 0) begin
      check("idle_gnt", 32'(gnt), 0);
      check("idle_busy", 32'(busy), 0);
      return;
    end
    check("gnt", 32'(gnt), 32'(1) << win);
    check("busy_e0", 32'(busy), 1);
    check("valid_e0", 32'(out_valid), 0);
    if (exp_gap > 0) check("gnt_gap", cyc - last_gnt, exp_gap);
    last_gnt = cyc;
    eb = ref_bin(g[win*W +: W]);
    if (!keep) begin
      req = N'($urandom);
      gray_in = rnd_gray();
    end
    @(posedge clk); @(negedge clk);
    check("valid_e1", 32'(out_valid), 1);
    check("bin", 32'(bin_out), 32'(eb));
    check("id", 32'(out_id), win);
    check("gnt_e1", 32'(gnt), 0);
    oid  = int'(out_id);
    obin = bin_out;
    repeat (hold) begin
      @(posedge clk); @(negedge clk);
      check("hold_valid", 32'(out_valid), 1);
      check("hold_bin", 32'(bin_out), 32'(eb));
      check("hold_id", 32'(out_id), win);
      check("hold_gnt", 32'(gnt), 0);
      check("hold_busy", 32'(busy), 1);
    end
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    check("done_valid", 32'(out_valid), 0);
    check("done_busy", 32'(busy), 0);
    check("done_gnt", 32'(gnt), 0);
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    mptr = 0;
  endtask

  task automatic reset_mid(input int edges);
    int win;
    req = '1; gray_in = rnd_gray(); out_ready = 1'b0;
    win = model_pick(req);
    repeat (edges) @(posedge clk);
    @(negedge clk);
    if (edges == 1) check("pre_gnt", 32'(gnt), 32'(1) << win);
    else            check("pre_valid", 32'(out_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 0);
    check("arst_gnt", 32'(gnt), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_bin", 32'(bin_out), 0);
    check("arst_id", 32'(out_id), 0);
    mptr = 0;
    req = '0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  initial begin
    int id;
    logic [W-1:0] b;
    logic [N*W-1:0] g;
    int rr_id[5];
    logic [W-1:0] rr_bin[5];
    rr_id  = '{0, 1, 2, 3, 0};
    rr_bin = '{4'b0000, 4'b0100, 4'b1111, 4'b1001, 4'b0000};

    rst_n = 1'b0; req = '0; gray_in = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_gnt", 32'(gnt), 0);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_bin", 32'(bin_out), 0);
    check("rst_id", 32'(out_id), 0);
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("quiet_gnt", 32'(gnt), 0);
      check("quiet_valid", 32'(out_valid), 0);
      check("quiet_busy", 32'(busy), 0);
      check("quiet_bin", 32'(bin_out), 0);
    end

    txn(4'b0100, 16'b0000_1101_0000_0000, 0, 0, 0, id, b);
    check("single_id", id, 2);
    check("single_bin", 32'(b), 32'(4'b1001));

    do_reset();
    g = {4'b1101, 4'b1000, 4'b0110, 4'b0000};
    for (int k = 0; k < 5; k++) begin
      txn(4'b1111, g, 0, 1, (k == 0) ? 0 : 3, id, b);
      check("rr_id", id, rr_id[k]);
      check("rr_bin", 32'(b), 32'(rr_bin[k]));
    end

    txn(4'b1111, g, 5, 1, 3, id, b);
    check("bp_id", id, 1);
    txn(4'b1111, g, 0, 1, 8, id, b);
    check("bp_next_id", id, 2);

    reset_mid(3);
    txn(4'b1010, rnd_gray(), 0, 0, 0, id, b);
    check("post_rst_id", id, 1);
    reset_mid(1);
    txn(4'b1010, rnd_gray(), 0, 0, 0, id, b);
    check("post_rst2_id", id, 1);

    for (int v = 0; v < 16; v++) begin
      g = rnd_gray();
      g[W-1:0] = W'(v);
      txn(4'b0001, g, 0, 0, 0, id, b);
      if (v == 1) check("ex_0001", 32'(b), 32'(4'b0001));
      if (v == 8) check("ex_1000", 32'(b), 32'(4'b1111));
    end

    repeat (60) begin
      txn(N'($urandom), rnd_gray(), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 0, id, b);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
